// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage: holds the PC, fetches one word at a time
// over req/ack, and presents registered decode fields over valid/ready.
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        illegal_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPW    = 7;
    localparam int unsigned REGW   = 5;
    localparam logic [OPW-1:0]  OP_IMM = 7'b0010011;
    localparam logic [OPW-1:0]  OP_REG = 7'b0110011;
    localparam logic [XLEN-1:0] NOP_IR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            req_q, valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [OPW-1:0]  opcode_q;
    logic [REGW-1:0] rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q;

    logic            capture_c;
    logic [XLEN-1:0] redir_pc_c;
    logic [XLEN-1:0] dec_imm_c;
    logic            dec_illegal_c;
    logic            unused_funct3_c;

    assign redir_pc_c      = redirect_pc_i & ~XLEN'(3);
    assign unused_funct3_c = ^imem_rdata_i[14:12];

    // Decode the incoming word so the held fields are registered at capture.
    always_comb begin
        dec_imm_c     = '0;
        dec_illegal_c = 1'b1;
        case (imem_rdata_i[OPW-1:0])
            OP_IMM: begin
                dec_imm_c     = {{20{imem_rdata_i[31]}}, imem_rdata_i[31:20]};
                dec_illegal_c = 1'b0;
            end
            OP_REG:  dec_illegal_c = 1'b0;
            default: ;
        endcase
    end

    // Next-state logic; pc_q doubles as the in-flight address while discarding.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        capture_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (redirect_valid_i) begin
                        pc_d = redir_pc_c;
                    end else begin
                        capture_c = 1'b1;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    pc_next_d = redir_pc_c;
                    state_d   = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (redirect_valid_i) begin
                    pc_next_d = redir_pc_c;
                end
                if (imem_ack_i) begin
                    pc_d    = redirect_valid_i ? redir_pc_c : pc_next_q;
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (out_ready_i || redirect_valid_i) begin
                    state_d = S_FETCH;
                end
                if (redirect_valid_i) begin
                    pc_d = redir_pc_c;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            out_pc_q  <= RESET_PC;
            opcode_q  <= NOP_IR[6:0];
            rd_q      <= NOP_IR[11:7];
            rs1_q     <= NOP_IR[19:15];
            rs2_q     <= NOP_IR[24:20];
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            req_q     <= (state_d != S_HOLD);
            valid_q   <= (state_d == S_HOLD);
            if (capture_c) begin
                out_pc_q  <= pc_q;
                opcode_q  <= imem_rdata_i[6:0];
                rd_q      <= imem_rdata_i[11:7];
                rs1_q     <= imem_rdata_i[19:15];
                rs2_q     <= imem_rdata_i[24:20];
                imm_q     <= dec_imm_c;
                illegal_q <= dec_illegal_c;
            end
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign out_valid_o = valid_q;
    assign out_pc_o    = out_pc_q;
    assign opcode_o    = opcode_q;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign imm_o       = imm_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        reset, ack, ready, rv;
    logic [31:0] rdata, rpc;
    logic        req, valid, illegal;
    logic [31:0] addr, out_pc, imm;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;

    logic        w_reset, w_req, w_valid, w_illegal;
    logic [31:0] w_addr, w_out_pc, w_imm;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    always #5 clk = ~clk;

    fetch_decode u_dut (
        .clk_i(clk), .reset_i(reset),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata),
        .out_valid_o(valid), .out_ready_i(ready), .out_pc_o(out_pc),
        .opcode_o(opcode), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
        .imm_o(imm), .illegal_o(illegal),
        .redirect_valid_i(rv), .redirect_pc_i(rpc)
    );

    fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .reset_i(w_reset),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(1'b1), .imem_rdata_i(32'h0050_0093),
        .out_valid_o(w_valid), .out_ready_i(1'b1), .out_pc_o(w_out_pc),
        .opcode_o(w_opcode), .rd_o(w_rd), .rs1_o(w_rs1), .rs2_o(w_rs2),
        .imm_o(w_imm), .illegal_o(w_illegal),
        .redirect_valid_i(1'b0), .redirect_pc_i(32'h0)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_imm(logic [31:0] w);
        if (w[6:0] == 7'h13) return $signed(w) >>> 20;
        return 32'h0;
    endfunction

    function automatic logic model_illegal(logic [31:0] w);
        return !(w[6:0] == 7'h13 || w[6:0] == 7'h33);
    endfunction

    // Transaction-level model: holding flag, drop-next-response flag, addresses.
    bit          m_valid, m_drop;
    logic [31:0] m_addr, m_rdr, m_ir, m_out_pc;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_drop   = 1'b0;
            m_addr   = 32'h0;
            m_ir     = 32'h13;
            m_out_pc = 32'h0;
        end else if (m_valid) begin
            if (ready || rv) m_valid = 1'b0;
            if (rv) m_addr = rpc & 32'hFFFF_FFFC;
        end else if (m_drop) begin
            if (rv) m_rdr = rpc & 32'hFFFF_FFFC;
            if (ack) begin
                m_addr = m_rdr;
                m_drop = 1'b0;
            end
        end else if (ack) begin
            if (rv) m_addr = rpc & 32'hFFFF_FFFC;
            else begin
                m_ir     = rdata;
                m_out_pc = m_addr;
                m_addr   = m_addr + 32'd4;
                m_valid  = 1'b1;
            end
        end else if (rv) begin
            m_drop = 1'b1;
            m_rdr  = rpc & 32'hFFFF_FFFC;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req",     32'(req),     32'(!m_valid));
            check("addr",    addr,         m_addr);
            check("valid",   32'(valid),   32'(m_valid));
            check("out_pc",  out_pc,       m_out_pc);
            check("opcode",  32'(opcode),  32'(m_ir[6:0]));
            check("rd",      32'(rd),      32'(m_ir[11:7]));
            check("rs1",     32'(rs1),     32'(m_ir[19:15]));
            check("rs2",     32'(rs2),     32'(m_ir[24:20]));
            check("imm",     imm,          model_imm(m_ir));
            check("illegal", 32'(illegal), 32'(model_illegal(m_ir)));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [31:0] held_pc;

    initial begin
        reset = 1'b1; ack = 1'b0; ready = 1'b1; rv = 1'b0;
        rdata = 32'h0; rpc = 32'h0; w_reset = 1'b1;
        step();
        chk_en = 1'b1;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_req",   32'(req),   32'h1);
        check("rst_addr",  addr,       32'h0);
        check("rst_imm",   imm,        32'h0);

        // Zero-wait stream of addi x1,x0,5: one instruction every two cycles.
        ack = 1'b1; rdata = 32'h0050_0093; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s_valid", 32'(valid), 32'h1);
            check("s_pc",    out_pc,     32'(i * 4));
            check("s_imm",   imm,        32'h5);
            check("s_rd",    32'(rd),    32'h1);
            check("s_op",    32'(opcode), 32'h13);
            step();
            check("s_gap", 32'(valid), 32'h0);
        end

        rdata = 32'hFFF0_8113;
        step();
        check("neg_pc",  out_pc, 32'd12);
        check("neg_imm", imm, 32'hFFFF_FFFF);
        check("neg_ill", 32'(illegal), 32'h0);
        check("neg_rs1", 32'(rs1), 32'h1);
        step();

        rdata = 32'h0020_81B3;
        step();
        check("r_rd",  32'(rd),  32'h3);
        check("r_rs1", 32'(rs1), 32'h1);
        check("r_rs2", 32'(rs2), 32'h2);
        check("r_imm", imm, 32'h0);
        check("r_ill", 32'(illegal), 32'h0);
        step();
        rdata = 32'h0000_0063;
        step();
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_valid", 32'(valid), 32'h1);
        step();

        // Backpressure for five cycles.
        ready = 1'b0; rdata = 32'h0050_0093;
        step();
        held_pc = out_pc;
        check("bp_pc", out_pc, 32'd24);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", 32'(valid), 32'h1);
            check("bp_req",   32'(req),   32'h0);
            check("bp_pc_st", out_pc,     held_pc);
        end
        ready = 1'b1;
        step();
        check("bp_rel_req",  32'(req), 32'h1);
        check("bp_rel_addr", addr,     32'd28);

        // Redirect while the fetch of 28 is waiting for ack.
        ack = 1'b0; rv = 1'b1; rpc = 32'h100;
        step();
        rv = 1'b0;
        check("dis_addr", addr, 32'd28);
        step();
        check("dis_addr2", addr, 32'd28);
        ack = 1'b1;
        step();
        check("dis_novalid", 32'(valid), 32'h0);
        check("dis_newaddr", addr, 32'h100);
        step();
        check("dis_pc", out_pc, 32'h100);

        // Redirect in HOLD without ready drops the held instruction.
        ready = 1'b0; rv = 1'b1; rpc = 32'h203;
        step();
        rv = 1'b0; ready = 1'b1;
        check("hr_valid", 32'(valid), 32'h0);
        check("hr_addr",  addr, 32'h200);
        step();
        check("hr_pc", out_pc, 32'h200);
        step();

        // Reset in the middle of a discard.
        ack = 1'b0; rv = 1'b1; rpc = 32'h300;
        step();
        rv = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rd_addr",  addr, 32'h0);
        check("rd_req",   32'(req), 32'h1);
        check("rd_valid", 32'(valid), 32'h0);
        ack = 1'b1;
        step();
        check("rd_fetch_pc", out_pc, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            ack   = ($urandom_range(0, 9) < 6);
            ready = $urandom_range(0, 1) == 1;
            rv    = ($urandom_range(0, 9) == 0);
            rpc   = $urandom;
            case ($urandom_range(0, 3))
                0:       rdata = {$urandom_range(0, 32'h01FF_FFFF) & 32'h01FF_FFFF, 7'h13} & 32'hFFFF_FFFF;
                1:       rdata = ($urandom & 32'hFFFF_FF80) | 32'h33;
                2:       rdata = ($urandom & 32'hFFFF_FF80) | 32'h13;
                default: rdata = $urandom;
            endcase
            step();
        end
        reset = 1'b1;
        step();
        chk_en = 1'b0;

        // Separate instance: PC wraps from 0xFFFF_FFFC to 0.
        check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
        check("w_rst_req",  32'(w_req), 32'h1);
        w_reset = 1'b0;
        step();
        check("w_valid1", 32'(w_valid), 32'h1);
        check("w_pc1",    w_out_pc, 32'hFFFF_FFFC);
        step();
        check("w_addr2", w_addr, 32'h0);
        step();
        check("w_pc2", w_out_pc, 32'h0);
        check("w_imm", w_imm, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
